// File: rtl/reduce_pkg.sv
// Shared definitions for the pipelined N-way reduction: op encodings, padding identity
// and tree-depth helper.
package reduce_pkg;

    typedef enum logic [1:0] {
        OP_OR  = 2'b00,
        OP_AND = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    // Value that leaves the op's result unchanged when used as padding.
    function automatic logic op_identity(input logic [1:0] op);
        return (op == OP_AND);
    endfunction

    function automatic int levels_of(input int width);
        return $clog2(width);
    endfunction

    // NOR travels through the tree as OR; it is inverted after the last level.
    function automatic logic op_pair(input logic [1:0] op, input logic a, input logic b);
        case (op)
            OP_AND:  return a & b;
            OP_XOR:  return a ^ b;
            default: return a | b;
        endcase
    endfunction

endpackage

// File: rtl/reduce_stage.sv
// One reduction tree level: pairwise reduce IN_W bits to IN_W/2 and register the result
// with the beat's op and valid. Everything holds while the global stall is high.
module reduce_stage
    import reduce_pkg::*;
#(
    parameter int IN_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic [IN_W-1:0]     in_data,
    input  logic [1:0]          in_op,
    input  logic                in_valid,
    output logic [IN_W/2-1:0]   out_data,
    output logic [1:0]          out_op,
    output logic                out_valid
);

    localparam int OUT_W = IN_W / 2;

    logic [OUT_W-1:0] pair;

    always_comb begin
        pair = '0;
        for (int i = 0; i < OUT_W; i++) begin
            pair[i] = op_pair(in_op, in_data[2*i], in_data[2*i+1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_op    <= OP_OR;
            out_valid <= 1'b0;
        end else if (!stall) begin
            out_data  <= pair;
            out_op    <= in_op;
            out_valid <= in_valid;
        end
    end

endmodule

// File: rtl/reduce_nway_pipe.sv
// Pipelined N-way OR/AND/XOR/NOR reduction, one register per tree level, valid/ready.
// Optional sticky result flag enabled by defining REDUCE_NWAY_STICKY_EN.
module reduce_nway_pipe
    import reduce_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_data,
    output logic [1:0]       out_op,
    output logic             out_valid,
    input  logic             out_ready
`ifdef REDUCE_NWAY_STICKY_EN
    ,
    input  logic             sticky_clr,
    output logic             sticky
`endif
);

    localparam int LEVELS = levels_of(WIDTH);
    localparam int PW     = 1 << LEVELS;

    if (WIDTH < 2 || WIDTH > 256) begin : g_bad_width
        $error("reduce_nway_pipe: WIDTH must be in 2..256");
    end

    logic              stall;
    logic [PW-1:0]     padded;
    // All tree levels packed back to back: level k starts at 2*PW - 2*(PW>>k).
    logic [2*PW-2:0]   tree;
    logic [LEVELS:0][1:0] op_pipe;
    logic [LEVELS:0]   vld_pipe;
    logic              last_d;
    logic [1:0]        last_o;

    if (PW > WIDTH) begin : g_pad
        assign padded = {{(PW-WIDTH){op_identity(in_op)}}, in_data};
    end else begin : g_nopad
        assign padded = in_data;
    end

    assign tree[PW-1:0] = padded;
    assign op_pipe[0]   = in_op;
    assign vld_pipe[0]  = in_valid;

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int IW   = PW >> k;
        localparam int IOFF = 2*PW - 2*IW;
        localparam int OOFF = 2*PW - IW;

        reduce_stage #(.IN_W(IW)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .stall     (stall),
            .in_data   (tree[IOFF +: IW]),
            .in_op     (op_pipe[k]),
            .in_valid  (vld_pipe[k]),
            .out_data  (tree[OOFF +: IW/2]),
            .out_op    (op_pipe[k+1]),
            .out_valid (vld_pipe[k+1])
        );
    end

    assign last_d    = tree[2*PW-2];
    assign last_o    = op_pipe[LEVELS];
    assign out_valid = vld_pipe[LEVELS];
    assign out_data  = last_d ^ (last_o == OP_NOR);
    assign out_op    = last_o;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

`ifdef REDUCE_NWAY_STICKY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky <= 1'b0;
        end else if (sticky_clr) begin
            sticky <= 1'b0;
        end else if (out_valid && out_ready && out_data) begin
            sticky <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_reduce_nway_pipe.sv
// Self-checking bench for reduce_nway_pipe: WIDTH=16 and WIDTH=12 instances, vector table,
// directed stall/reset/sticky sequences and a randomized run against a queue-based model.
module tb_reduce_nway_pipe;

    localparam int W   = 16;
    localparam int W12 = 12;
    localparam int L   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0]   a_in_data = '0;
    logic [1:0]     a_in_op = '0;
    logic           a_in_valid = 1'b0, a_in_ready, a_out_data, a_out_valid, a_out_ready = 1'b1;
    logic [1:0]     a_out_op;
    logic [W12-1:0] b_in_data = '0;
    logic [1:0]     b_in_op = '0;
    logic           b_in_valid = 1'b0, b_in_ready, b_out_data, b_out_valid, b_out_ready = 1'b1;
    logic [1:0]     b_out_op;
`ifdef REDUCE_NWAY_STICKY_EN
    logic a_sticky_clr = 1'b0, a_sticky, b_sticky_clr = 1'b0, b_sticky;
`endif

    reduce_nway_pipe #(.WIDTH(W)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_data(a_in_data), .in_op(a_in_op), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_op(a_out_op), .out_valid(a_out_valid), .out_ready(a_out_ready)
`ifdef REDUCE_NWAY_STICKY_EN
        , .sticky_clr(a_sticky_clr), .sticky(a_sticky)
`endif
    );

    reduce_nway_pipe #(.WIDTH(W12)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_data(b_in_data), .in_op(b_in_op), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_op(b_out_op), .out_valid(b_out_valid), .out_ready(b_out_ready)
`ifdef REDUCE_NWAY_STICKY_EN
        , .sticky_clr(b_sticky_clr), .sticky(b_sticky)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: count the ones in the unpadded word and apply the op's definition.
    function automatic logic ref_reduce(input logic [31:0] d, input int w, input logic [1:0] op);
        int ones = 0;
        for (int i = 0; i < w; i++) if (d[i]) ones++;
        case (op)
            2'b00:   return ones > 0;
            2'b01:   return ones == w;
            2'b10:   return (ones % 2) == 1;
            default: return ones == 0;
        endcase
    endfunction

    typedef struct {
        logic       d;
        logic [1:0] op;
        int         acc_cyc;
        int         acc_stalls;
    } exp_t;

    exp_t q[$];
    bit   head_seen = 1'b0;
    bit   sb_en = 1'b0;
    int   cyc = 0;
    int   stall_cnt = 0;

    // Scoreboard for the WIDTH=16 instance; latency excludes cycles spent stalled.
    always @(negedge clk) begin
        cyc++;
        if (rst_n && sb_en) begin
            if (a_out_valid) begin
                if (q.size() == 0) begin
                    check("sb_spurious_out", int'(a_out_valid), 0);
                end else begin
                    if (!head_seen) begin
                        check("sb_latency", cyc - q[0].acc_cyc - (stall_cnt - q[0].acc_stalls), L);
                        head_seen = 1'b1;
                    end
                    check("sb_data", int'(a_out_data), int'(q[0].d));
                    check("sb_op", int'(a_out_op), int'(q[0].op));
                    if (a_out_ready) begin
                        void'(q.pop_front());
                        head_seen = 1'b0;
                    end
                end
                if (!a_out_ready) stall_cnt++;
            end
            check("sb_in_ready", int'(a_in_ready), int'(!(a_out_valid && !a_out_ready)));
            if (a_in_valid && a_in_ready)
                q.push_back('{ref_reduce(32'(a_in_data), W, a_in_op), a_in_op, cyc, stall_cnt});
        end
    end

    typedef struct {
        bit         sel;
        logic [15:0] data;
        logic [1:0] op;
        logic       exp;
    } vec_t;

    vec_t vecs[16];

    task automatic run_vec(input int i);
        int k;
        bit got;
        @(posedge clk); #1;
        if (!vecs[i].sel) begin
            a_in_data = vecs[i].data; a_in_op = vecs[i].op; a_in_valid = 1'b1;
        end else begin
            b_in_data = vecs[i].data[11:0]; b_in_op = vecs[i].op; b_in_valid = 1'b1;
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        got = 1'b0;
        k = 0;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            got = vecs[i].sel ? b_out_valid : a_out_valid;
        end
        check($sformatf("vec%0d_latency", i), k, L);
        check($sformatf("vec%0d_data", i), int'(vecs[i].sel ? b_out_data : a_out_data), int'(vecs[i].exp));
        check($sformatf("vec%0d_op", i), int'(vecs[i].sel ? b_out_op : a_out_op), int'(vecs[i].op));
    endtask

    task automatic send_a(input logic [15:0] d, input logic [1:0] op);
        @(posedge clk); #1;
        a_in_data = d; a_in_op = op; a_in_valid = 1'b1;
    endtask

    task automatic drain(input string name);
        int g = 0;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        while (q.size() != 0 && g < 50) begin
            @(negedge clk); #1;
            g++;
        end
        check(name, q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, first, last, n, g;
        bit acc;
        logic       held_d;
        logic [1:0] held_o;

        vecs[0]  = '{1'b0, 16'h0000, 2'b00, 1'b0};
        vecs[1]  = '{1'b0, 16'h0100, 2'b00, 1'b1};
        vecs[2]  = '{1'b0, 16'hFFFF, 2'b01, 1'b1};
        vecs[3]  = '{1'b0, 16'hFFFE, 2'b01, 1'b0};
        vecs[4]  = '{1'b0, 16'h8001, 2'b10, 1'b0};
        vecs[5]  = '{1'b0, 16'h0001, 2'b10, 1'b1};
        vecs[6]  = '{1'b0, 16'h0000, 2'b11, 1'b1};
        vecs[7]  = '{1'b0, 16'h0200, 2'b11, 1'b0};
        vecs[8]  = '{1'b1, 16'h0FFF, 2'b01, 1'b1};
        vecs[9]  = '{1'b1, 16'h0FFE, 2'b01, 1'b0};
        vecs[10] = '{1'b1, 16'h0007, 2'b10, 1'b1};
        vecs[11] = '{1'b1, 16'h0000, 2'b00, 1'b0};
        vecs[12] = '{1'b1, 16'h0800, 2'b00, 1'b1};
        vecs[13] = '{1'b1, 16'h0000, 2'b11, 1'b1};
        vecs[14] = '{1'b1, 16'h0003, 2'b10, 1'b0};
        vecs[15] = '{1'b1, 16'h0800, 2'b11, 1'b0};

        #12;
        check("rst_a_out_valid", int'(a_out_valid), 0);
        check("rst_a_in_ready", int'(a_in_ready), 1);
        check("rst_a_out_data", int'(a_out_data), 0);
        check("rst_a_out_op", int'(a_out_op), 0);
        check("rst_b_out_valid", int'(b_out_valid), 0);
        check("rst_b_in_ready", int'(b_in_ready), 1);
`ifdef REDUCE_NWAY_STICKY_EN
        check("rst_a_sticky", int'(a_sticky), 0);
        check("rst_b_sticky", int'(b_sticky), 0);
`endif
        #20 rst_n = 1'b1;
        sb_en = 1'b1;

        for (int i = 0; i < 16; i++) run_vec(i);
        drain("drain_vectors");

        // Back-to-back beats with rotating ops, one result per cycle.
        cnt = 0; first = -1; last = -1;
        fork
            begin
                for (int i = 0; i < 8; i++) send_a(16'($urandom), 2'(i));
                @(posedge clk); #1;
                a_in_valid = 1'b0;
            end
            begin
                for (int n2 = 0; n2 < 24; n2++) begin
                    @(negedge clk);
                    if (a_out_valid) begin
                        cnt++;
                        if (first < 0) first = n2;
                        last = n2;
                    end
                end
            end
        join
        check("b2b_count", cnt, 8);
        check("b2b_span", last - first, 7);
        drain("drain_b2b");

        // Full pipeline held by out_ready=0 for five cycles.
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 16'($urandom);
        a_in_op     = 2'($urandom);
        g = 0;
        while (g < 20) begin
            @(negedge clk);
            acc = a_in_valid && a_in_ready;
            if (a_out_valid) break;
            @(posedge clk); #1;
            if (acc) begin a_in_data = 16'($urandom); a_in_op = 2'($urandom); end
            g++;
        end
        check("stall_fill_timeout", int'(a_out_valid), 1);
        held_d = a_out_data;
        held_o = a_out_op;
        for (int s = 0; s < 5; s++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("stall_in_ready", int'(a_in_ready), 0);
            check("stall_out_valid", int'(a_out_valid), 1);
            check("stall_out_data", int'(a_out_data), int'(held_d));
            check("stall_out_op", int'(a_out_op), int'(held_o));
        end
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        n = 0; g = 0;
        while (n < 5 && g < 30) begin
            @(negedge clk);
            if (a_in_valid && a_in_ready) n++;
            @(posedge clk); #1;
            if (n >= 5) a_in_valid = 1'b0;
            else begin a_in_data = 16'($urandom); a_in_op = 2'($urandom); end
            g++;
        end
        drain("drain_stall");

        // Randomized traffic with random back-pressure.
        for (int r = 0; r < 400; r++) begin
            @(posedge clk); #1;
            a_in_valid  = ($urandom_range(3) != 0);
            a_out_ready = ($urandom_range(3) != 0);
            a_in_data   = 16'($urandom);
            a_in_op     = 2'($urandom);
            if (r % 7 == 0) a_in_data = (r % 2 == 0) ? 16'h0000 : 16'hFFFF;
        end
        @(posedge clk); #1;
        drain("drain_random");

        // Asynchronous reset while results are waiting.
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_a(16'hFFFF, 2'b00);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        g = 0;
        while (!a_out_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("rst_mid_fill", int'(a_out_valid), 1);
        #2;
        sb_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", int'(a_out_valid), 0);
        check("rst_mid_in_ready", int'(a_in_ready), 1);
        check("rst_mid_out_data", int'(a_out_data), 0);
        check("rst_mid_out_op", int'(a_out_op), 0);
        check("rst_mid_b_out_valid", int'(b_out_valid), 0);
        q.delete();
        head_seen = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        sb_en = 1'b1;
        for (int i = 0; i < L + 2; i++) begin
            @(negedge clk);
            check("rst_post_idle", int'(a_out_valid), 0);
        end
        run_vec(1);
        drain("drain_reset");

`ifdef REDUCE_NWAY_STICKY_EN
        @(posedge clk); #1;
        a_sticky_clr = 1'b1;
        @(posedge clk); #1;
        a_sticky_clr = 1'b0;
        @(negedge clk);
        check("sticky_cleared", int'(a_sticky), 0);
        send_a(16'h0000, 2'b00);
        send_a(16'h0001, 2'b00);
        send_a(16'h0000, 2'b00);
        @(posedge clk); #1;
        drain("drain_sticky");
        @(negedge clk);
        check("sticky_set", int'(a_sticky), 1);
        send_a(16'h0001, 2'b00);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        g = 0;
        while (!a_out_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("sticky_clr_result", int'(a_out_data), 1);
        a_sticky_clr = 1'b1;
        @(posedge clk); #1;
        a_sticky_clr = 1'b0;
        check("sticky_clr_priority", int'(a_sticky), 0);
        @(negedge clk);
        check("sticky_clr_hold", int'(a_sticky), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
